obstacle_spawner: RTL and testbench

- Consumer end of the 5-bit LFSR random stream.
- Turns random values into timed obstacle spawn events for the renderer, and requests an LFSR advance after each value it consumes.
- Sits between the random generator and the obstacle draw/scroll logic.
- Runs on the game pixel clock and is paced by the per-frame tick.

---
 rtl/dino_pkg.sv | 28 ++
 rtl/spawn_gap_calc.sv | 29 ++
 rtl/obstacle_spawner.sv | 132 +++++++++++++
 tb/tb_obstacle_spawner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// Shared types for the dino game: obstacle kinds, spawner states and the
// bit fields carved out of the 5-bit LFSR value.
package dino_pkg;

  typedef enum logic [1:0] {
    OBST_CACTUS_S = 2'd0,
    OBST_CACTUS_L = 2'd1,
    OBST_CACTUS_D = 2'd2,
    OBST_BIRD     = 2'd3
  } obst_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SPAWN = 2'd2
  } spawn_state_e;

  localparam int RND_TYPE_LSB = 0;
  localparam int RND_TYPE_MSB = 1;
  localparam int RND_HIGH_BIT = 2;
  localparam int RND_GAP_LSB  = 3;
  localparam int RND_GAP_MSB  = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spawn_gap_calc.sv
// Combinational reload gap: cur_min + bits*GAP_STEP, saturated to the
// counter width and clamped to at least one frame.
module spawn_gap_calc #(
  parameter int GAP_W    = 8,
  parameter int GAP_STEP = 16
) (
  input  logic [GAP_W-1:0] cur_min,
  input  logic [1:0]       bits,
  output logic [GAP_W-1:0] gap
);

  localparam int SUM_W = GAP_W + 34;
  localparam logic [SUM_W-1:0] STEP_X  = SUM_W'(GAP_STEP);
  localparam logic [SUM_W-1:0] GAP_MAX = {{34{1'b0}}, {GAP_W{1'b1}}};

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = SUM_W'(cur_min) + SUM_W'(bits) * STEP_X;
    if (sum > GAP_MAX) begin
      gap = '1;
    end else if (sum == '0) begin
      gap = GAP_W'(1);
    end else begin
      gap = sum[GAP_W-1:0];
    end
  end

endmodule

// File: rtl/obstacle_spawner.sv
// Turns LFSR values into frame-timed obstacle spawn handshakes.
// Optional macro OBST_SPEEDUP_EN shrinks the minimum gap as the game goes on.
module obstacle_spawner
  import dino_pkg::*;
#(
  parameter int GAP_W          = 8,
  parameter int FIRST_GAP      = 90,
  parameter int MIN_GAP        = 40,
  parameter int GAP_STEP       = 16,
  parameter int SPEEDUP_SPAWNS = 8,
  parameter int FLOOR_GAP      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             game_run,
  input  logic             frame_tick,
  input  logic [4:0]       random1,
  output logic             rand_next,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [1:0]       spawn_type,
  output logic             spawn_high,
  output logic [7:0]       spawn_count,
  output logic [GAP_W-1:0] gap_remaining
);

  spawn_state_e     state, state_n;
  logic [GAP_W-1:0] gap_n, cur_min, cur_min_n, cur_min_hs, gap_reload;
  logic [7:0]       count_n, count_inc;
  logic [1:0]       type_n, rand_gap_q, rand_gap_n;
  logic             high_n, valid_n, rn_n;

  assign count_inc = sat_inc8(spawn_count);

`ifdef OBST_SPEEDUP_EN
  // The reduced minimum takes effect on the reload of the same handshake.
  always_comb begin
    cur_min_hs = cur_min;
    if (((32'(count_inc) % SPEEDUP_SPAWNS) == 0) && (cur_min > GAP_W'(FLOOR_GAP))) begin
      cur_min_hs = cur_min - GAP_W'(1);
    end
  end
`else
  assign cur_min_hs = cur_min;
`endif

  spawn_gap_calc #(
    .GAP_W    (GAP_W),
    .GAP_STEP (GAP_STEP)
  ) u_gap_calc (
    .cur_min (cur_min_hs),
    .bits    (rand_gap_q),
    .gap     (gap_reload)
  );

  always_comb begin
    state_n    = state;
    gap_n      = gap_remaining;
    count_n    = spawn_count;
    type_n     = spawn_type;
    high_n     = spawn_high;
    valid_n    = spawn_valid;
    rn_n       = 1'b0;
    rand_gap_n = rand_gap_q;
    cur_min_n  = cur_min;
    // Leaving the game wins over everything, including a pending handshake.
    if (!game_run) begin
      state_n = ST_IDLE;
      valid_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gap_n     = GAP_W'(FIRST_GAP);
          count_n   = '0;
          cur_min_n = GAP_W'(MIN_GAP);
          state_n   = ST_COUNT;
        end
        ST_COUNT: begin
          if (frame_tick) begin
            gap_n = gap_remaining - GAP_W'(1);
            if (gap_remaining == GAP_W'(1)) begin
              rand_gap_n = random1[RND_GAP_MSB:RND_GAP_LSB];
              type_n     = random1[RND_TYPE_MSB:RND_TYPE_LSB];
              high_n     = random1[RND_HIGH_BIT];
              valid_n    = 1'b1;
              rn_n       = 1'b1;
              state_n    = ST_SPAWN;
            end
          end
        end
        ST_SPAWN: begin
          if (spawn_ready) begin
            count_n   = count_inc;
            cur_min_n = cur_min_hs;
            gap_n     = gap_reload;
            valid_n   = 1'b0;
            state_n   = ST_COUNT;
          end
        end
        default: begin
          state_n = ST_IDLE;
          valid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      gap_remaining <= '0;
      spawn_count   <= '0;
      spawn_type    <= '0;
      spawn_high    <= 1'b0;
      spawn_valid   <= 1'b0;
      rand_next     <= 1'b0;
      rand_gap_q    <= '0;
      cur_min       <= GAP_W'(MIN_GAP);
    end else begin
      state         <= state_n;
      gap_remaining <= gap_n;
      spawn_count   <= count_n;
      spawn_type    <= type_n;
      spawn_high    <= high_n;
      spawn_valid   <= valid_n;
      rand_next     <= rn_n;
      rand_gap_q    <= rand_gap_n;
      cur_min       <= cur_min_n;
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Bench for obstacle_spawner: directed vector table, corner sequences and a
// randomized run against a spec-level model; optionally built with OBST_SPEEDUP_EN.
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       game_run = 1'b0, frame_tick = 1'b0, spawn_ready = 1'b0;
  logic       gr2 = 1'b0, tk2 = 1'b0, rdy2 = 1'b0;
  logic [4:0] random1 = '0;

  logic       rand_next, spawn_valid, spawn_high;
  logic [1:0] spawn_type;
  logic [7:0] spawn_count, gap_remaining;
  logic       rn2, valid2, high2;
  logic [1:0] type2;
  logic [7:0] count2, gap2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  obstacle_spawner dut (
    .clk(clk), .reset(reset), .game_run(game_run), .frame_tick(frame_tick),
    .random1(random1), .rand_next(rand_next), .spawn_valid(spawn_valid),
    .spawn_ready(spawn_ready), .spawn_type(spawn_type), .spawn_high(spawn_high),
    .spawn_count(spawn_count), .gap_remaining(gap_remaining)
  );

  obstacle_spawner #(.MIN_GAP(1), .FIRST_GAP(1), .GAP_STEP(0)) dut2 (
    .clk(clk), .reset(reset), .game_run(gr2), .frame_tick(tk2),
    .random1(random1), .rand_next(rn2), .spawn_valid(valid2),
    .spawn_ready(rdy2), .spawn_type(type2), .spawn_high(high2),
    .spawn_count(count2), .gap_remaining(gap2)
  );

  // Spec-level model: mode 0 idle, 1 counting frames, 2 waiting for renderer.
  typedef struct {
    int mode; int gap; int cnt; int typ; int high;
    int valid; int rn; int rq; int cmin;
  } model_t;

  model_t m1, m2;

  function automatic model_t mstep(model_t m, bit rst, bit gr, bit tk, logic [4:0] r,
                                   bit rdy, int min_g, int first_g, int step_g);
    model_t n = m;
    int g;
    n.rn = 0;
    if (rst) begin
      n = '{default: 0};
      n.cmin = min_g;
      return n;
    end
    if (!gr) begin
      n.mode = 0;
      n.valid = 0;
      return n;
    end
    if (m.mode == 0) begin
      n.gap = first_g; n.cnt = 0; n.cmin = min_g; n.mode = 1;
    end else if (m.mode == 1) begin
      if (tk) begin
        n.gap = m.gap - 1;
        if (m.gap == 1) begin
          n.rq = int'(r); n.typ = int'(r) % 4; n.high = (int'(r) / 4) % 2;
          n.valid = 1; n.rn = 1; n.mode = 2;
        end
      end
    end else if (rdy) begin
      n.cnt = (m.cnt >= 255) ? 255 : m.cnt + 1;
`ifdef OBST_SPEEDUP_EN
      if ((n.cnt % 8) == 0 && m.cmin > 20) n.cmin = m.cmin - 1;
`endif
      g = n.cmin + (m.rq / 8) * step_g;
      if (g > 255) g = 255;
      if (g < 1) g = 1;
      n.gap = g; n.valid = 0; n.mode = 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    m1 = mstep(m1, reset, game_run, frame_tick, random1, spawn_ready, 40, 90, 16);
    m2 = mstep(m2, reset, gr2, tk2, random1, rdy2, 1, 1, 0);
    @(posedge clk);
    #1;
    chk("dut spawn_valid", int'(spawn_valid), m1.valid);
    chk("dut rand_next", int'(rand_next), m1.rn);
    chk("dut spawn_count", int'(spawn_count), m1.cnt);
    chk("dut gap_remaining", int'(gap_remaining), m1.gap);
    chk("dut spawn_type", int'(spawn_type), m1.typ);
    chk("dut spawn_high", int'(spawn_high), m1.high);
    chk("dut2 spawn_valid", int'(valid2), m2.valid);
    chk("dut2 rand_next", int'(rn2), m2.rn);
    chk("dut2 spawn_count", int'(count2), m2.cnt);
    chk("dut2 gap_remaining", int'(gap2), m2.gap);
    chk("dut2 spawn_type", int'(type2), m2.typ);
    chk("dut2 spawn_high", int'(high2), m2.high);
  endtask

  typedef struct {
    bit gr; bit tk; bit rdy; logic [4:0] rnd; int rep;
    int valid; int rn; int typ; int high; int cnt; int gap;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int k;
    bit hit;
    m1 = '{default: 0}; m1.cmin = 40;
    m2 = '{default: 0}; m2.cmin = 1;

    //          gr tk rdy rnd       rep  vld rn typ hi cnt gap
    vecs.push_back('{0, 0, 0, 5'b00000, 1,  0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 1, 0, 5'b10110, 1,  0, 0, 0, 0, 0, 90});
    vecs.push_back('{1, 1, 0, 5'b10110, 89, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 1, 0, 5'b10110, 1,  1, 1, 2, 1, 0, 0});
    vecs.push_back('{1, 1, 0, 5'b10110, 1,  1, 0, 2, 1, 0, 0});
    vecs.push_back('{1, 1, 0, 5'b00001, 9,  1, 0, 2, 1, 0, 0});
    vecs.push_back('{1, 0, 1, 5'b00001, 1,  0, 0, 2, 1, 1, 72});
    vecs.push_back('{1, 1, 0, 5'b01011, 71, 0, 0, 2, 1, 1, 1});
    vecs.push_back('{1, 1, 0, 5'b01011, 1,  1, 1, 3, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 5'b01011, 1,  0, 0, 3, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 5'b01011, 3,  0, 0, 3, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 5'b01011, 1,  0, 0, 3, 0, 0, 90});
    vecs.push_back('{1, 1, 0, 5'b01011, 90, 1, 1, 3, 0, 0, 0});
    vecs.push_back('{1, 1, 1, 5'b01011, 1,  0, 0, 3, 0, 1, 56});

    reset = 1'b1;
    step();
    reset = 1'b0;

    foreach (vecs[i]) begin
      game_run = vecs[i].gr; frame_tick = vecs[i].tk;
      spawn_ready = vecs[i].rdy; random1 = vecs[i].rnd;
      repeat (vecs[i].rep) step();
      chk($sformatf("vec%0d valid", i), int'(spawn_valid), vecs[i].valid);
      chk($sformatf("vec%0d rand_next", i), int'(rand_next), vecs[i].rn);
      chk($sformatf("vec%0d type", i), int'(spawn_type), vecs[i].typ);
      chk($sformatf("vec%0d high", i), int'(spawn_high), vecs[i].high);
      chk($sformatf("vec%0d count", i), int'(spawn_count), vecs[i].cnt);
      chk($sformatf("vec%0d gap", i), int'(gap_remaining), vecs[i].gap);
    end

    // Reset in the middle of a game returns everything to zero.
    spawn_ready = 1'b0; frame_tick = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("midreset gap", int'(gap_remaining), 0);
    chk("midreset count", int'(spawn_count), 0);
    chk("midreset type", int'(spawn_type), 0);
    reset = 1'b0;

    // Eight quick accepted spawns with gap bits 00: check the 8th reload.
    random1 = 5'b00000; game_run = 1'b1; frame_tick = 1'b1; spawn_ready = 1'b1;
    hit = 1'b0;
    for (k = 0; k < 2000 && !hit; k++) begin
      step();
      if (spawn_count == 8'd8) hit = 1'b1;
    end
    chk("speedup reached 8 spawns", int'(hit), 1);
`ifdef OBST_SPEEDUP_EN
    chk("8th reload gap", int'(gap_remaining), 39);
`else
    chk("8th reload gap", int'(gap_remaining), 40);
`endif
    game_run = 1'b0;
    step();

    // Count saturation on the short-gap instance.
    gr2 = 1'b1; tk2 = 1'b1; rdy2 = 1'b1;
    repeat (600) step();
    chk("saturated count", int'(count2), 255);
    repeat (20) step();
    chk("count stays saturated", int'(count2), 255);
    gr2 = 1'b0;

    // Randomized run against the model.
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 299) == 0);
      game_run    = ($urandom_range(0, 39) != 0);
      frame_tick  = $urandom_range(0, 1) == 1;
      spawn_ready = ($urandom_range(0, 2) == 0);
      random1     = 5'($urandom);
      gr2         = ($urandom_range(0, 19) != 0);
      tk2         = $urandom_range(0, 1) == 1;
      rdy2        = $urandom_range(0, 1) == 1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
